// File: rtl/rom_read_arbiter.sv
// Two-port read arbiter in front of a single combinational program ROM.
// Port 0 (instruction fetch) has fixed priority. A wait counter forces
// port 1 (debug/loader) through after MAX_WAIT consecutive denied cycles.
// The ROM word read in the grant cycle is registered and returned to the
// granted port on the next edge as a one-cycle rvalid pulse.
module rom_read_arbiter #(
  parameter int unsigned AW       = 16,
  parameter int unsigned DW       = 16,
  parameter int unsigned DEPTH    = 1024,
  parameter int unsigned MAX_WAIT = 4
) (
  input  logic          clk,
  input  logic          rst_n,

  input  logic          req0,
  input  logic [AW-1:0] addr0,
  output logic          gnt0,
  output logic          rvalid0,
  output logic [DW-1:0] rdata0,
  output logic          rerr0,

  input  logic          req1,
  input  logic [AW-1:0] addr1,
  output logic          gnt1,
  output logic          rvalid1,
  output logic [DW-1:0] rdata1,
  output logic          rerr1,

  output logic [AW-1:0] rom_ad,
  input  logic [DW-1:0] rom_data
);

  // One extra bit so DEPTH == 2**AW still compares correctly.
  localparam logic [AW:0] DepthW  = (AW+1)'(DEPTH);
  localparam logic [3:0]  MaxWait = 4'(MAX_WAIT);

  logic [3:0] wait_cnt_q;
  logic [3:0] wait_cnt_d;
  logic       force_gnt;
  logic       in_range0;
  logic       in_range1;

  // Address range decode for both requesters.
  always_comb begin
    in_range0 = ({1'b0, addr0} < DepthW);
    in_range1 = ({1'b0, addr1} < DepthW);
  end

  // Fixed-priority arbitration, overridden for port 1 once it has waited MAX_WAIT cycles.
  always_comb begin
    force_gnt = req1 && (wait_cnt_q == MaxWait);
    gnt1      = req1 && (force_gnt || !req0);
    gnt0      = req0 && !gnt1;
  end

  // ROM address mux; out-of-range or idle cycles park the ROM at address 0.
  always_comb begin
    rom_ad = '0;
    if (gnt0 && in_range0) begin
      rom_ad = addr0;
    end else if (gnt1 && in_range1) begin
      rom_ad = addr1;
    end
  end

  // Starvation counter: counts consecutive denied port-1 cycles, saturating at MAX_WAIT.
  always_comb begin
    wait_cnt_d = '0;
    if (req1 && !gnt1) begin
      wait_cnt_d = (wait_cnt_q == MaxWait) ? MaxWait : wait_cnt_q + 4'd1;
    end
  end

  // Wait counter state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wait_cnt_q <= '0;
    end else begin
      wait_cnt_q <= wait_cnt_d;
    end
  end

  // Port 0 response register; data/err only update on a port 0 grant.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rvalid0 <= 1'b0;
      rdata0  <= '0;
      rerr0   <= 1'b0;
    end else begin
      rvalid0 <= gnt0;
      if (gnt0) begin
        rdata0 <= in_range0 ? rom_data : '0;
        rerr0  <= !in_range0;
      end
    end
  end

  // Port 1 response register; data/err only update on a port 1 grant.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rvalid1 <= 1'b0;
      rdata1  <= '0;
      rerr1   <= 1'b0;
    end else begin
      rvalid1 <= gnt1;
      if (gnt1) begin
        rdata1 <= in_range1 ? rom_data : '0;
        rerr1  <= !in_range1;
      end
    end
  end

endmodule

// File: tb/tb_rom_read_arbiter.sv
// Scoreboard bench for rom_read_arbiter: the stimulus process checks grants
// and rom_ad and queues expected responses; a monitor on the falling edge
// pops and compares each rvalid pulse and checks hold behaviour otherwise.
`timescale 1ns/1ps
module tb_rom_read_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req0, req1;
  logic [15:0] addr0, addr1;
  logic        gnt0, gnt1;
  logic        rvalid0, rvalid1;
  logic [15:0] rdata0, rdata1;
  logic        rerr0, rerr1;
  logic [15:0] rom_ad;
  logic [15:0] rom_data;

  logic [15:0] mem [1024];

  typedef struct {
    int          due;
    logic [15:0] data;
    logic        err;
  } resp_t;

  resp_t q0[$];
  resp_t q1[$];

  int vectors = 0;
  int errors  = 0;
  int cyc     = 0;

  logic [15:0] last_d0, last_d1;
  logic        last_e0, last_e1;

  rom_read_arbiter #(
    .AW(16), .DW(16), .DEPTH(1024), .MAX_WAIT(4)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .req0     (req0),
    .addr0    (addr0),
    .gnt0     (gnt0),
    .rvalid0  (rvalid0),
    .rdata0   (rdata0),
    .rerr0    (rerr0),
    .req1     (req1),
    .addr1    (addr1),
    .gnt1     (gnt1),
    .rvalid1  (rvalid1),
    .rdata1   (rdata1),
    .rerr1    (rerr1),
    .rom_ad   (rom_ad),
    .rom_data (rom_data)
  );

  always #5 clk = ~clk;

  // Combinational ROM model; garbage beyond the array so a bad range check shows up.
  assign rom_data = (rom_ad < 16'd1024) ? mem[rom_ad[9:0]] : 16'hDEAD;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic resp_t exp_resp(input logic [15:0] a);
    resp_t r;
    r.due  = cyc + 1;
    r.err  = (a >= 16'd1024);
    r.data = r.err ? 16'h0000 : mem[a[9:0]];
    return r;
  endfunction

  // One cycle: drive at posedge+1, check grants at posedge+3, queue expected responses.
  task automatic step(input logic r0, input logic [15:0] a0, input logic r1,
                      input logic [15:0] a1, input logic eg0, input logic eg1,
                      input string name);
    logic [15:0] ead;
    req0 = r0; addr0 = a0; req1 = r1; addr1 = a1;
    #2;
    ead = 16'h0000;
    if (eg0 && a0 < 16'd1024) ead = a0;
    if (eg1 && a1 < 16'd1024) ead = a1;
    chk({name, " gnt0"}, gnt0, eg0);
    chk({name, " gnt1"}, gnt1, eg1);
    chk({name, " rom_ad"}, rom_ad, ead);
    if (eg0) q0.push_back(exp_resp(a0));
    if (eg1) q1.push_back(exp_resp(a1));
    @(posedge clk); #1;
  endtask

  // Monitor: compare responses due this cycle, otherwise require no pulse and held data.
  always @(negedge clk) begin
    resp_t e;
    if (!rst_n) begin
      last_d0 = 16'h0; last_e0 = 1'b0; last_d1 = 16'h0; last_e1 = 1'b0;
    end else begin
      if (q0.size() > 0 && q0[0].due == cyc) begin
        e = q0.pop_front();
        chk("rvalid0", rvalid0, 1'b1);
        chk("rdata0", rdata0, e.data);
        chk("rerr0", rerr0, e.err);
        last_d0 = e.data; last_e0 = e.err;
      end else begin
        chk("rvalid0 idle", rvalid0, 1'b0);
        chk("rdata0 hold", rdata0, last_d0);
        chk("rerr0 hold", rerr0, last_e0);
      end
      if (q1.size() > 0 && q1[0].due == cyc) begin
        e = q1.pop_front();
        chk("rvalid1", rvalid1, 1'b1);
        chk("rdata1", rdata1, e.data);
        chk("rerr1", rerr1, e.err);
        last_d1 = e.data; last_e1 = e.err;
      end else begin
        chk("rvalid1 idle", rvalid1, 1'b0);
        chk("rdata1 hold", rdata1, last_d1);
        chk("rerr1 hold", rerr1, last_e1);
      end
    end
  end

  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = 16'(i * 40503) ^ 16'h1234;
    mem[5]    = 16'hABCD;
    mem[7]    = 16'h7777;
    mem[1023] = 16'hC0DE;

    rst_n = 1'b0;
    req0 = 1'b0; req1 = 1'b0; addr0 = 16'h0; addr1 = 16'h0;
    #2;
    chk("reset rvalid0", rvalid0, 1'b0);
    chk("reset rvalid1", rvalid1, 1'b0);
    chk("reset rdata0", rdata0, 16'h0);
    chk("reset rdata1", rdata1, 16'h0);
    chk("reset rerr0", rerr0, 1'b0);
    chk("reset rerr1", rerr1, 1'b0);
    chk("reset rom_ad", rom_ad, 16'h0);
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Single read
    step(1, 16'd5, 0, 16'd0, 1, 0, "single");
    step(0, 16'd0, 0, 16'd0, 0, 0, "idle");

    // Starvation bound: port 1 forced through on its 5th requesting cycle
    step(1, 16'd0, 1, 16'd7, 1, 0, "starve c1");
    step(1, 16'd1, 1, 16'd7, 1, 0, "starve c2");
    step(1, 16'd2, 1, 16'd7, 1, 0, "starve c3");
    step(1, 16'd3, 1, 16'd7, 1, 0, "starve c4");
    step(1, 16'd4, 1, 16'd7, 0, 1, "starve c5 forced");
    // Counter must have cleared: four more denials before the next force
    step(1, 16'd4, 1, 16'd8, 1, 0, "restart c1");
    step(1, 16'd5, 1, 16'd8, 1, 0, "restart c2");
    step(1, 16'd6, 1, 16'd8, 1, 0, "restart c3");
    step(1, 16'd7, 1, 16'd8, 1, 0, "restart c4");
    step(1, 16'd8, 1, 16'd8, 0, 1, "restart c5 forced");

    // Dropping req1 before grant clears the counter
    step(1, 16'd8, 1, 16'd9, 1, 0, "drop c1");
    step(1, 16'd9, 1, 16'd9, 1, 0, "drop c2");
    step(1, 16'd10, 0, 16'd9, 1, 0, "drop gap");
    step(1, 16'd11, 1, 16'd9, 1, 0, "drop c3");
    step(1, 16'd12, 1, 16'd9, 1, 0, "drop c4");
    step(1, 16'd13, 1, 16'd9, 1, 0, "drop c5");
    step(1, 16'd14, 1, 16'd9, 1, 0, "drop c6");
    step(1, 16'd15, 1, 16'd9, 0, 1, "drop c7 forced");
    step(0, 16'd15, 0, 16'd0, 0, 0, "idle");

    // Idle port 0, top in-range address
    step(0, 16'd0, 1, 16'd1023, 0, 1, "p1 last word");
    step(1, 16'd1023, 0, 16'd0, 1, 0, "p0 last word");

    // Out of range on port 1
    step(0, 16'd0, 1, 16'd1024, 0, 1, "p1 depth");
    step(0, 16'd0, 0, 16'd0, 0, 0, "idle");

    // Back-to-back alternation
    for (int i = 0; i < 8; i++) begin
      if (i % 2 == 0) step(1, 16'(100 + i), 0, 16'd0, 1, 0, $sformatf("alt %0d", i));
      else            step(0, 16'd0, 1, 16'(200 + i), 0, 1, $sformatf("alt %0d", i));
    end

    // Out of range on port 0, no wrap
    step(1, 16'hFFFF, 0, 16'd0, 1, 0, "p0 ffff");
    step(0, 16'd0, 0, 16'd0, 0, 0, "idle");

    // Asynchronous reset mid-cycle with a port 0 grant in flight
    req0 = 1'b1; addr0 = 16'd33;
    #2;
    chk("rst gnt0", gnt0, 1'b1);
    rst_n = 1'b0;
    #1;
    chk("rst rvalid0", rvalid0, 1'b0);
    chk("rst rvalid1", rvalid1, 1'b0);
    chk("rst rdata0", rdata0, 16'h0);
    chk("rst rdata1", rdata1, 16'h0);
    chk("rst rerr0", rerr0, 1'b0);
    chk("rst rerr1", rerr1, 1'b0);
    req0 = 1'b0;
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) step(0, 16'd0, 0, 16'd0, 0, 0, "post reset");

    chk("q0 drained", q0.size(), 0);
    chk("q1 drained", q1.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
